// File: rtl/keypad_debouncer.sv
// Counter-timed debouncer for keypad scan results: synchronises key_pressed/sig_in,
// accepts a press or release only after DEBOUNCE_CYCLES stable clocks. Optional auto-repeat: DEBOUNCER_AUTOREPEAT_EN.
module keypad_debouncer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4000000,
   parameter int SYNC_STAGES     = 2,
   parameter int REPEAT_DELAY    = 24000000,
   parameter int REPEAT_PERIOD   = 6000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_in,
   input  logic             key_pressed,
   output logic [WIDTH-1:0] sig_out,
   output logic             sig_new,
   output logic             sig_valid
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keypad_debouncer: illegal parameter value");
   end

   typedef enum logic [1:0] {
      WAIT_LOW      = 2'd0,
      DEBOUNCE_UP   = 2'd1,
      WAIT_HIGH     = 2'd2,
      DEBOUNCE_DOWN = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] cand, cand_next;
   logic             fire_press, fire_release, fire_repeat;
   logic             press_q, release_q, repeat_q;

   logic [SYNC_STAGES-1:0] kp_sync;
   logic [WIDTH-1:0]       code_sync [SYNC_STAGES];
   logic                   kp_s;
   logic [WIDTH-1:0]       code_s;

   assign kp_s   = kp_sync[SYNC_STAGES-1];
   assign code_s = code_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kp_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) code_sync[i] <= '0;
      end else begin
         kp_sync      <= {kp_sync[SYNC_STAGES-2:0], key_pressed};
         code_sync[0] <= sig_in;
         for (int i = 1; i < SYNC_STAGES; i++) code_sync[i] <= code_sync[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WAIT_LOW;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         cand  <= cand_next;
      end
   end

   // The counter stops at CNT_LAST because every exit from a debounce state clears it.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      cand_next    = cand;
      fire_press   = 1'b0;
      fire_release = 1'b0;
      case (state)
         WAIT_LOW: begin
            cnt_next = '0;
            if (kp_s) begin
               state_next = DEBOUNCE_UP;
               cand_next  = code_s;
            end
         end
         DEBOUNCE_UP: begin
            if (!kp_s || code_s != cand) begin
               state_next = WAIT_LOW;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = WAIT_HIGH;
               cnt_next   = '0;
               fire_press = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (!kp_s) state_next = DEBOUNCE_DOWN;
         end
         DEBOUNCE_DOWN: begin
            if (kp_s) begin
               state_next = WAIT_HIGH;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next   = WAIT_LOW;
               cnt_next     = '0;
               fire_release = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = WAIT_LOW;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef DEBOUNCER_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX) + 1;

   logic [RW-1:0] rep_cnt, rep_limit;
   logic          rep_first;

   // First repeat waits REPEAT_DELAY; a release bounce back into WAIT_HIGH resumes at REPEAT_PERIOD.
   assign rep_limit   = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
   assign fire_repeat = (state == WAIT_HIGH) && kp_s && (rep_cnt == rep_limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         if (state != WAIT_HIGH || fire_repeat) rep_cnt <= '0;
         else                                   rep_cnt <= rep_cnt + RW'(1);
         if (fire_press)                                         rep_first <= 1'b1;
         else if (fire_repeat || state_next == DEBOUNCE_DOWN)    rep_first <= 1'b0;
      end
   end
`else
   assign fire_repeat = 1'b0;
`endif

   // Outputs are retimed one clock behind the FSM decision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         sig_out   <= '0;
         sig_new   <= 1'b0;
         sig_valid <= 1'b0;
      end else begin
         press_q   <= fire_press;
         release_q <= fire_release;
         repeat_q  <= fire_repeat;
         sig_new   <= press_q | repeat_q;
         if (press_q) sig_out <= cand;
         if (press_q)        sig_valid <= 1'b1;
         else if (release_q) sig_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES=8; expected values hand-derived.
// Auto-repeat expectations apply when DEBOUNCER_AUTOREPEAT_EN is defined.
module tb_keypad_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sig_in;
   logic       key_pressed;
   logic [3:0] sig_out;
   logic       sig_new;
   logic       sig_valid;

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;
   int consec_cnt = 0;
   logic prev_new = 1'b0;

   keypad_debouncer #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(8),
      .SYNC_STAGES(2),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sig_in(sig_in),
      .key_pressed(key_pressed),
      .sig_out(sig_out),
      .sig_new(sig_new),
      .sig_valid(sig_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (sig_new) strobe_cnt++;
      if (sig_new && prev_new) consec_cnt++;
      prev_new = sig_new;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset       = 1'b0;
      key_pressed = 1'b0;
      sig_in      = 4'h0;
      #23;
      check("reset_out", 32'(sig_out), 32'h0);
      check("reset_new", 32'(sig_new), 32'h0);
      check("reset_valid", 32'(sig_valid), 32'h0);

      @(posedge clk);
      #1;
      reset = 1'b1;
      strobe_cnt = 0;
      run(20);
      check("idle_strobes", 32'(strobe_cnt), 32'd0);
      check("idle_valid", 32'(sig_valid), 32'h0);

      // Clean press of 4'hA: strobe in the 12th sampled cycle (edge k+11).
      key_pressed = 1'b1;
      sig_in      = 4'hA;
      run(11);
      check("press_before_new", 32'(sig_new), 32'h0);
      tick();
      check("press_new", 32'(sig_new), 32'h1);
      check("press_out", 32'(sig_out), 32'hA);
      check("press_valid", 32'(sig_valid), 32'h1);
      tick();
      check("press_new_one_cycle", 32'(sig_new), 32'h0);
`ifdef DEBOUNCER_AUTOREPEAT_EN
      strobe_cnt = 0;
      run(18);
      check("rep_quiet", 32'(strobe_cnt), 32'd0);
      tick();
      check("rep_first_20", 32'(sig_new), 32'h1);
      strobe_cnt = 0;
      run(4);
      check("rep_gap1", 32'(strobe_cnt), 32'd0);
      tick();
      check("rep_25", 32'(sig_new), 32'h1);
      strobe_cnt = 0;
      run(4);
      check("rep_gap2", 32'(strobe_cnt), 32'd0);
      tick();
      check("rep_30", 32'(sig_new), 32'h1);
      check("rep_out", 32'(sig_out), 32'hA);
`else
      strobe_cnt = 0;
      run(30);
      check("hold_single_strobe", 32'(strobe_cnt), 32'd0);
`endif

      // Clean release: sig_valid drops at edge r+11.
      key_pressed = 1'b0;
      strobe_cnt = 0;
      run(11);
      check("release_valid_held", 32'(sig_valid), 32'h1);
      tick();
      check("release_valid_drop", 32'(sig_valid), 32'h0);
      check("release_out_kept", 32'(sig_out), 32'hA);
      check("release_strobes", 32'(strobe_cnt), 32'd0);

      // Asynchronous reset in the middle of a debounce.
      key_pressed = 1'b1;
      sig_in      = 4'hC;
      run(6);
      #3;
      reset = 1'b0;
      #1;
      check("async_out", 32'(sig_out), 32'h0);
      check("async_new", 32'(sig_new), 32'h0);
      check("async_valid", 32'(sig_valid), 32'h0);
      key_pressed = 1'b0;
      run(2);
      reset = 1'b1;
      strobe_cnt = 0;
      run(20);
      check("post_reset_strobes", 32'(strobe_cnt), 32'd0);
      check("post_reset_out", 32'(sig_out), 32'h0);

      // Establish sig_out=4'hE, then release.
      key_pressed = 1'b1;
      sig_in      = 4'hE;
      strobe_cnt = 0;
      run(15);
      check("e_strobes", 32'(strobe_cnt), 32'd1);
      key_pressed = 1'b0;
      run(15);
      check("e_out", 32'(sig_out), 32'hE);
      check("e_valid", 32'(sig_valid), 32'h0);

      // Bounce: 3 high / 2 low, five times.
      sig_in = 4'h6;
      strobe_cnt = 0;
      for (int b = 0; b < 5; b++) begin
         key_pressed = 1'b1;
         run(3);
         key_pressed = 1'b0;
         run(2);
      end
      run(20);
      check("bounce_strobes", 32'(strobe_cnt), 32'd0);
      check("bounce_out", 32'(sig_out), 32'hE);
      check("bounce_valid", 32'(sig_valid), 32'h0);

      // Code change mid-debounce restarts it.
      key_pressed = 1'b1;
      sig_in      = 4'h3;
      strobe_cnt = 0;
      run(5);
      sig_in = 4'h7;
      run(20);
      check("codechg_strobes", 32'(strobe_cnt), 32'd1);
      check("codechg_out", 32'(sig_out), 32'h7);
      check("codechg_valid", 32'(sig_valid), 32'h1);
      key_pressed = 1'b0;
      strobe_cnt = 0;
      run(15);
      check("codechg_rel_strobes", 32'(strobe_cnt), 32'd0);
      check("codechg_rel_valid", 32'(sig_valid), 32'h0);

      // Hold 4'h5, second key ignored, short release ignored, full release.
      key_pressed = 1'b1;
      sig_in      = 4'h5;
      strobe_cnt = 0;
      run(15);
      check("hold5_strobes", 32'(strobe_cnt), 32'd1);
      check("hold5_out", 32'(sig_out), 32'h5);
      sig_in = 4'h9;
      strobe_cnt = 0;
      run(10);
      check("second_key_strobes", 32'(strobe_cnt), 32'd0);
      check("second_key_out", 32'(sig_out), 32'h5);
      key_pressed = 1'b0;
      run(4);
      key_pressed = 1'b1;
      strobe_cnt = 0;
      run(10);
`ifdef DEBOUNCER_AUTOREPEAT_EN
      check("short_rel_strobes", 32'(strobe_cnt), 32'd1);
`else
      check("short_rel_strobes", 32'(strobe_cnt), 32'd0);
`endif
      check("short_rel_valid", 32'(sig_valid), 32'h1);
      check("short_rel_out", 32'(sig_out), 32'h5);
      key_pressed = 1'b0;
      strobe_cnt = 0;
      run(11);
      check("full_rel_valid_held", 32'(sig_valid), 32'h1);
      tick();
      check("full_rel_valid_drop", 32'(sig_valid), 32'h0);
      check("full_rel_out", 32'(sig_out), 32'h5);
      check("full_rel_strobes", 32'(strobe_cnt), 32'd0);

      check("no_consecutive_strobes", 32'(consec_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
Parametrised, counter-timed debouncer for keypad scan results. It sits between the keypad scanner and the display/key-history logic. It synchronises a raw "key pressed" flag and a WIDTH-bit key code, then requires both to stay stable for DEBOUNCE_CYCLES clocks. Only then does it register the code and emit a one-cycle new-key strobe; release is qualified the same way, so exactly one strobe is produced per physical press.

Parameters:
WIDTH, 4, bit width of key code sig_in/sig_out
DEBOUNCE_CYCLES, 4000000, stable clocks required to accept a press or a release (~83 ms at 48 MHz); legal range >= 2
SYNC_STAGES, 2, flip-flop stages on key_pressed and sig_in; legal range >= 2
REPEAT_DELAY, 24000000, hold clocks before the first auto-repeat (used only with DEBOUNCER_AUTOREPEAT_EN)
REPEAT_PERIOD, 6000000, clocks between later auto-repeats (used only with DEBOUNCER_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-low reset
sig_in  input  WIDTH  raw key code from the scanner; asynchronous to clk
key_pressed  input  1  raw "some key down" flag from the scanner; asynchronous to clk
sig_out  output  WIDTH  last accepted key code; held until the next accepted press
sig_new  output  1  one-cycle strobe when sig_out is updated, or on auto-repeat
sig_valid  output  1  high from press acceptance until release acceptance

Behaviour:
- Reset:
  - Asserting reset (low) at any time, including mid-debounce, immediately clears state to WAIT_LOW, counter to 0, all synchroniser flops to 0, sig_out to 0, sig_new to 0 and sig_valid to 0.
  - Deassertion needs no special handling beyond the synchronisers.
- Synchronisers: key_pressed and sig_in each pass through SYNC_STAGES flops; kp_s and code_s denote the synchronised values. The FSM uses only kp_s and code_s.
- Counter: width $clog2(DEBOUNCE_CYCLES)+1; cleared on every state entry; increments by 1 per cycle in the DEBOUNCE states; never wraps.
- FSM (registered, one transition per clock edge):
  - WAIT_LOW:
    - kp_s=1 -> DEBOUNCE_UP; capture code_s into internal cand; counter=0.
  - DEBOUNCE_UP:
    - kp_s=0, or code_s!=cand -> WAIT_LOW (no output change).
    - Otherwise, when counter==DEBOUNCE_CYCLES-1 -> WAIT_HIGH; sig_out<=cand, sig_new=1 for exactly that following cycle, sig_valid<=1.
  - WAIT_HIGH:
    - kp_s=0 -> DEBOUNCE_DOWN; counter=0.
    - Changes to code_s while kp_s=1 are ignored; no new strobe for a second key.
  - DEBOUNCE_DOWN:
    - kp_s=1 -> WAIT_HIGH; no strobe, sig_out unchanged.
    - When counter==DEBOUNCE_CYCLES-1 -> WAIT_LOW; sig_valid<=0; sig_out keeps its value.
  - Unused encodings -> WAIT_LOW.
- Latency (SYNC_STAGES=2): a clean raw press sampled high at edge k gives sig_new high in the cycle after edge k+DEBOUNCE_CYCLES+3. That is DEBOUNCE_CYCLES+3 cycles. Release drops sig_valid DEBOUNCE_CYCLES+3 cycles after a clean raw release.
- Bounce shorter than DEBOUNCE_CYCLES produces no strobe and no sig_out change.
- sig_new is never high for two consecutive cycles, except in the auto-repeat case below.

Optional Feature:
- Macro: DEBOUNCER_AUTOREPEAT_EN.
- When defined:
  - In WAIT_HIGH, a second counter runs from 0.
  - At count REPEAT_DELAY-1, sig_new pulses for one cycle and the counter reloads to 0.
  - Each later pulse fires at REPEAT_PERIOD-1; sig_out is unchanged.
  - Entering DEBOUNCE_DOWN stops the repeat counter. A return to WAIT_HIGH from DEBOUNCE_DOWN resumes the REPEAT_PERIOD spacing.
  - Reset clears the repeat counter.
- When undefined: no repeat counter logic exists, and exactly one strobe is produced per accepted press.

Test Plan:
- DEBOUNCE_CYCLES=8: reset low mid-run -> all outputs 0 at once, asynchronously. Release reset, hold key_pressed=0 -> sig_valid=0, sig_new never asserts.
- Clean press, sig_in=4'hA, key_pressed held high -> sig_new high for 1 cycle, 11 cycles after the first sampled high edge. sig_out=4'hA, sig_valid=1.
- key_pressed toggles high 3 cycles / low 2 cycles, repeated 5 times, then stays low -> no sig_new, sig_out stays at its previous value.
- Code 4'h3 held 5 cycles, then changes to 4'h7 with key_pressed high throughout -> debounce restarts. A single strobe fires with sig_out=4'h7.
- Holding 4'h5, sig_in changes to 4'h9 -> no strobe. Release for 4 cycles, re-press -> no strobe, sig_valid stays 1. Full release of 8+ cycles -> sig_valid=0, sig_out still 4'h5.
- With DEBOUNCER_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, held key -> strobes at acceptance, then 20, 25 and 30 cycles after acceptance. Release stops further strobes.
